// File: rtl/dsp_pkg.sv
// Shared DSP types: synthesizer frame control word and a popcount helper.
// The control struct is sized for the 16-channel synthesizer.
package dsp_pkg;

    localparam int SYNTH_NUM_CHANNELS = 16;
    localparam int SYNTH_INDEX_WIDTH  = $clog2(SYNTH_NUM_CHANNELS);

    typedef struct packed {
        logic                         valid;
        logic                         last;
        logic [SYNTH_INDEX_WIDTH-1:0] data_index;
        logic                         transmit_active;
        logic [SYNTH_INDEX_WIDTH:0]   active_channel_count;
    } synthesizer_control_t;

    function automatic int unsigned count_ones(input logic [127:0] value);
        int unsigned total;
        total = 0;
        for (int b = 0; b < 128; b++) begin
            total = total + 32'(value[b]);
        end
        return total;
    endfunction

endpackage

// File: rtl/synthesizer_frame_builder_pkg.sv
// Local types and helpers for the synthesizer frame builder.
package synthesizer_frame_builder_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } frame_state_t;

    localparam int IQ_I = 0;
    localparam int IQ_Q = 1;

    function automatic int timer_width(input int interval);
        return (interval > 1) ? $clog2(interval) : 1;
    endfunction

endpackage

// File: rtl/synthesizer_frame_builder_if.sv
// Sample-input / frame-output bundle of the synthesizer frame builder.
interface synthesizer_frame_builder_if #(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 16
);
    import dsp_pkg::*;

    logic [NUM_CHANNELS-1:0]        Channel_enable;
    logic                           Input_valid;
    logic [CHANNEL_INDEX_WIDTH-1:0] Input_index;
    logic signed [DATA_WIDTH-1:0]   Input_data [2];
    synthesizer_control_t           Output_ctrl;
    logic signed [DATA_WIDTH-1:0]   Output_data [2];
    logic                           Error_input_overflow;
    logic                           Error_frame_underflow;

    modport master (
        output Channel_enable, Input_valid, Input_index, Input_data,
        input  Output_ctrl, Output_data, Error_input_overflow, Error_frame_underflow
    );

    modport slave (
        input  Channel_enable, Input_valid, Input_index, Input_data,
        output Output_ctrl, Output_data, Error_input_overflow, Error_frame_underflow
    );

endinterface

// File: rtl/synthesizer_frame_buffer.sv
// Two-bank IQ sample store with per-bank pending bitmaps; i_swap flips the
// write bank and clears the bank that becomes the new write bank.
module synthesizer_frame_buffer #(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_swap,
    input  logic                           i_wr_en,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] i_wr_index,
    input  logic signed [DATA_WIDTH-1:0]   i_wr_i,
    input  logic signed [DATA_WIDTH-1:0]   i_wr_q,
    input  logic                           i_rd_bank,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] i_rd_index,
    output logic                           o_wr_bank,
    output logic [NUM_CHANNELS-1:0]        o_wr_pending,
    output logic signed [DATA_WIDTH-1:0]   o_rd_i,
    output logic signed [DATA_WIDTH-1:0]   o_rd_q
);
    logic                         r_wr_bank;
    logic [NUM_CHANNELS-1:0]      r_pending [2];
    logic signed [DATA_WIDTH-1:0] r_bank_i [2][NUM_CHANNELS];
    logic signed [DATA_WIDTH-1:0] r_bank_q [2][NUM_CHANNELS];

    logic                         w_tgt_bank;
    logic [NUM_CHANNELS-1:0]      w_wr_onehot;
    logic [NUM_CHANNELS-1:0]      w_tgt_pending_next;

    // A write on the swap cycle already targets the bank being freshly cleared.
    assign w_tgt_bank         = i_swap ? ~r_wr_bank : r_wr_bank;
    assign w_wr_onehot        = i_wr_en ? (NUM_CHANNELS'(1) << i_wr_index) : '0;
    assign w_tgt_pending_next = (i_swap ? '0 : r_pending[w_tgt_bank]) | w_wr_onehot;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_bank    <= 1'b0;
            r_pending[0] <= '0;
            r_pending[1] <= '0;
        end else begin
            if (i_swap) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (i_swap || i_wr_en) begin
                r_pending[w_tgt_bank] <= w_tgt_pending_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_bank_i[w_tgt_bank][i_wr_index] <= i_wr_i;
            r_bank_q[w_tgt_bank][i_wr_index] <= i_wr_q;
        end
    end

    assign o_wr_bank    = r_wr_bank;
    assign o_wr_pending = r_pending[r_wr_bank];
    assign o_rd_i       = r_bank_i[i_rd_bank][i_rd_index];
    assign o_rd_q       = r_bank_q[i_rd_bank][i_rd_index];

endmodule

// File: rtl/synthesizer_frame_builder.sv
// Collects per-channel IQ writes into a double buffer and emits one
// channel-interleaved, zero-filled frame per frame tick.
module synthesizer_frame_builder
    import dsp_pkg::*;
    import synthesizer_frame_builder_pkg::*;
#(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 16,
    parameter int FRAME_INTERVAL      = 32
) (
    input  logic                      Clk,
    input  logic                      Rst,
    synthesizer_frame_builder_if.slave bus
);
    localparam int TIMER_W = timer_width(FRAME_INTERVAL);
    localparam int COUNT_W = CHANNEL_INDEX_WIDTH + 1;
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_BEAT = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

    frame_state_t                   r_state;
    logic [TIMER_W-1:0]             r_timer;
    logic [CHANNEL_INDEX_WIDTH-1:0] r_beat;
    logic [NUM_CHANNELS-1:0]        r_valid_mask;
    logic [COUNT_W-1:0]             r_count;
    synthesizer_control_t           r_ctrl;
    logic signed [DATA_WIDTH-1:0]   r_out_i;
    logic signed [DATA_WIDTH-1:0]   r_out_q;
    logic                           r_err_ovf;
    logic                           r_err_udf;

    logic                           w_tick;
    logic                           w_wr_bank;
    logic [NUM_CHANNELS-1:0]        w_wr_pending;
    logic                           w_rd_bank;
    logic [CHANNEL_INDEX_WIDTH-1:0] w_rd_index;
    logic [NUM_CHANNELS-1:0]        w_mask;
    logic signed [DATA_WIDTH-1:0]   w_rd_i;
    logic signed [DATA_WIDTH-1:0]   w_rd_q;
    logic signed [DATA_WIDTH-1:0]   w_beat_i;
    logic signed [DATA_WIDTH-1:0]   w_beat_q;
    logic [COUNT_W-1:0]             w_count;
    logic                           w_start;
    logic                           w_overflow;
    logic                           w_underflow;

    assign w_tick = (r_timer == TIMER_W'(FRAME_INTERVAL - 1));

    synthesizer_frame_buffer #(
        .NUM_CHANNELS       (NUM_CHANNELS),
        .CHANNEL_INDEX_WIDTH(CHANNEL_INDEX_WIDTH),
        .DATA_WIDTH         (DATA_WIDTH)
    ) u_buffer (
        .i_clk       (Clk),
        .i_rst       (Rst),
        .i_swap      (w_tick),
        .i_wr_en     (bus.Input_valid),
        .i_wr_index  (bus.Input_index),
        .i_wr_i      (bus.Input_data[IQ_I]),
        .i_wr_q      (bus.Input_data[IQ_Q]),
        .i_rd_bank   (w_rd_bank),
        .i_rd_index  (w_rd_index),
        .o_wr_bank   (w_wr_bank),
        .o_wr_pending(w_wr_pending),
        .o_rd_i      (w_rd_i),
        .o_rd_q      (w_rd_q)
    );

    // Beat 0 is registered on the tick itself, straight from the bank being retired.
    assign w_rd_bank   = w_tick ? w_wr_bank : ~w_wr_bank;
    assign w_rd_index  = w_tick ? '0 : r_beat;
    assign w_mask      = w_tick ? (w_wr_pending & bus.Channel_enable) : r_valid_mask;
    assign w_beat_i    = w_mask[w_rd_index] ? w_rd_i : '0;
    assign w_beat_q    = w_mask[w_rd_index] ? w_rd_q : '0;
    assign w_count     = COUNT_W'(count_ones(128'(bus.Channel_enable)));
    assign w_start     = w_tick && (bus.Channel_enable != '0);
    assign w_overflow  = bus.Input_valid && !w_tick && w_wr_pending[bus.Input_index];
    assign w_underflow = w_tick && ((bus.Channel_enable & ~w_wr_pending) != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_beat       <= '0;
            r_valid_mask <= '0;
            r_count      <= '0;
            r_ctrl       <= '0;
            r_out_i      <= '0;
            r_out_q      <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
        end else begin
            r_timer   <= w_tick ? '0 : r_timer + TIMER_W'(1);
            r_err_ovf <= w_overflow;
            r_err_udf <= w_underflow;
            r_ctrl    <= '0;
            r_out_i   <= '0;
            r_out_q   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_valid_mask                <= w_mask;
                        r_count                     <= w_count;
                        r_beat                      <= CHANNEL_INDEX_WIDTH'(1);
                        r_ctrl.valid                <= 1'b1;
                        r_ctrl.last                 <= (NUM_CHANNELS == 1);
                        r_ctrl.data_index           <= '0;
                        r_ctrl.transmit_active      <= 1'b1;
                        r_ctrl.active_channel_count <= w_count;
                        r_out_i                     <= w_beat_i;
                        r_out_q                     <= w_beat_q;
                        r_state                     <= (NUM_CHANNELS > 1) ? S_EMIT : S_IDLE;
                    end
                end
                S_EMIT: begin
                    r_ctrl.valid                <= 1'b1;
                    r_ctrl.last                 <= (r_beat == LAST_BEAT);
                    r_ctrl.data_index           <= r_beat;
                    r_ctrl.transmit_active      <= 1'b1;
                    r_ctrl.active_channel_count <= r_count;
                    r_out_i                     <= w_beat_i;
                    r_out_q                     <= w_beat_q;
                    r_beat                      <= r_beat + CHANNEL_INDEX_WIDTH'(1);
                    if (r_beat == LAST_BEAT) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Output_ctrl           = r_ctrl;
    assign bus.Output_data[IQ_I]     = r_out_i;
    assign bus.Output_data[IQ_Q]     = r_out_q;
    assign bus.Error_input_overflow  = r_err_ovf;
    assign bus.Error_frame_underflow = r_err_udf;

endmodule

// File: tb/tb_synthesizer_frame_builder.sv
// Directed and randomized bench for synthesizer_frame_builder with a
// frame-level reference model.
module tb_synthesizer_frame_builder;
    import dsp_pkg::*;

    localparam int N   = 16;
    localparam int CIW = 4;
    localparam int FI  = 32;
    localparam int DW  = 16;

    logic clk = 1'b0;
    logic rst;

    synthesizer_frame_builder_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) bus ();

    synthesizer_frame_builder #(
        .NUM_CHANNELS  (N),
        .DATA_WIDTH    (DW),
        .FRAME_INTERVAL(FI)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [N-1:0] en_r = '0;

    // Reference model: samples pending for the next frame, and the frame in flight.
    bit               m_pend [N];
    logic signed [DW-1:0] m_i [N];
    logic signed [DW-1:0] m_q [N];
    logic signed [DW-1:0] f_i [N];
    logic signed [DW-1:0] f_q [N];
    int               f_base  = -1000;
    int               f_count = 0;

    logic [31:0] obs_d [N];
    int ovf_seen    = 0;
    int udf_seen    = 0;
    int udf_cyc     = -1;
    int valid_seen  = 0;
    int first_valid = -1;

    function automatic logic [31:0] pack_iq(input int i, input int q);
        return {16'(q), 16'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit vld, input int idx, input int di, input int dq);
        bit tick;
        bit e_ovf;
        bit e_udf;
        int b;
        synthesizer_control_t ec;
        logic [31:0] ed;
        bus.Channel_enable = en_r;
        bus.Input_valid    = vld;
        bus.Input_index    = CIW'(idx);
        bus.Input_data[0]  = DW'(di);
        bus.Input_data[1]  = DW'(dq);
        tick  = ((cyc % FI) == FI - 1);
        e_ovf = vld && !tick && m_pend[idx];
        e_udf = 1'b0;
        if (tick) begin
            for (int k = 0; k < N; k++) if (en_r[k] && !m_pend[k]) e_udf = 1'b1;
            if (en_r != '0) begin
                for (int k = 0; k < N; k++) begin
                    f_i[k] = (en_r[k] && m_pend[k]) ? m_i[k] : '0;
                    f_q[k] = (en_r[k] && m_pend[k]) ? m_q[k] : '0;
                end
                f_count = $countones(en_r);
                f_base  = cyc + 1;
            end
            for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
        end
        if (vld) begin
            m_pend[idx] = 1'b1;
            m_i[idx]    = DW'(di);
            m_q[idx]    = DW'(dq);
        end
        cyc++;
        @(posedge clk);
        #1;
        ec = '0;
        ed = '0;
        b  = cyc - f_base;
        if (b >= 0 && b < N) begin
            ec.valid                = 1'b1;
            ec.last                 = (b == N - 1);
            ec.data_index           = CIW'(b);
            ec.transmit_active      = 1'b1;
            ec.active_channel_count = 5'(f_count);
            ed                      = {f_q[b], f_i[b]};
        end
        chk("ctrl", 64'(bus.Output_ctrl), 64'(ec));
        chk("data", 64'({bus.Output_data[1], bus.Output_data[0]}), 64'(ed));
        chk("overflow", 64'(bus.Error_input_overflow), 64'(e_ovf));
        chk("underflow", 64'(bus.Error_frame_underflow), 64'(e_udf));
        if (bus.Output_ctrl.valid) begin
            obs_d[bus.Output_ctrl.data_index] = {bus.Output_data[1], bus.Output_data[0]};
            valid_seen++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (bus.Error_input_overflow) ovf_seen++;
        if (bus.Error_frame_underflow) begin
            udf_seen++;
            udf_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 0);
    endtask

    task automatic finish_interval();
        while ((cyc % FI) != 0) step(1'b0, 0, 0, 0);
    endtask

    task automatic rst_step();
        rst = 1'b1;
        bus.Input_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ctrl", 64'(bus.Output_ctrl), 64'(0));
        chk("rst_data", 64'({bus.Output_data[1], bus.Output_data[0]}), 64'(0));
        chk("rst_overflow", 64'(bus.Error_input_overflow), 64'(0));
        chk("rst_underflow", 64'(bus.Error_frame_underflow), 64'(0));
        rst = 1'b0;
        cyc = 0;
        f_base = -1000;
        first_valid = -1;
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
    endtask

    initial begin
        int base;
        int ri;
        int rq;
        rst                = 1'b1;
        bus.Channel_enable = '0;
        bus.Input_valid    = 1'b0;
        bus.Input_index    = '0;
        bus.Input_data[0]  = '0;
        bus.Input_data[1]  = '0;
        rst_step();
        rst_step();

        // Single enabled channel, one write per interval.
        en_r = 16'h0001;
        for (int f = 0; f < 3; f++) begin
            idle($urandom_range(0, 20));
            step(1'b1, 0, 100, -100);
            finish_interval();
        end

        // All channels written with (k,-k).
        en_r = 16'hFFFF;
        for (int k = 0; k < N; k++) step(1'b1, k, k, -k);
        valid_seen = 0;
        finish_interval();
        idle(N + 1);
        chk("full_valid_beats", 64'(valid_seen), 64'(N));
        chk("full_beat7", 64'(obs_d[7]), 64'(pack_iq(7, -7)));
        chk("full_beat15", 64'(obs_d[15]), 64'(pack_iq(15, -15)));
        finish_interval();

        // Double write to channel 3: newest wins, one overflow.
        en_r = 16'h0008;
        ovf_seen = 0;
        idle(2);
        step(1'b1, 3, 5, 5);
        idle(3);
        step(1'b1, 3, 7, 7);
        finish_interval();
        idle(N + 1);
        chk("dup_overflow_count", 64'(ovf_seen), 64'(1));
        chk("dup_beat3", 64'(obs_d[3]), 64'(pack_iq(7, 7)));
        finish_interval();

        // Enabled but unwritten channel 1: underflow and zero fill.
        en_r = 16'h0003;
        base = cyc;
        idle(20);
        step(1'b1, 0, 11, -22);
        for (int k = 0; k < N; k++) obs_d[k] = 32'hDEAD_BEEF;
        finish_interval();
        idle(N + 1);
        chk("udf_timing", 64'(udf_cyc), 64'(base + FI));
        chk("udf_beat1_zero", 64'(obs_d[1]), 64'(0));
        chk("udf_beat0", 64'(obs_d[0]), 64'(pack_iq(11, -22)));
        finish_interval();

        // Write on the tick cycle lands in the following frame.
        en_r = 16'h0004;
        ovf_seen = 0;
        ri = int'(16'($urandom));
        rq = int'(16'($urandom));
        idle(FI - 1);
        step(1'b1, 2, ri, rq);
        for (int k = 0; k < N; k++) obs_d[k] = 32'hDEAD_BEEF;
        idle(N);
        chk("tick_write_absent", 64'(obs_d[2]), 64'(0));
        finish_interval();
        idle(N + 1);
        chk("tick_write_next", 64'(obs_d[2]), 64'(pack_iq(ri, rq)));
        chk("tick_write_no_overflow", 64'(ovf_seen), 64'(0));
        finish_interval();

        // No channels enabled: nothing emitted, no underflow.
        en_r = '0;
        idle(N + 1);
        valid_seen = 0;
        udf_seen   = 0;
        finish_interval();
        idle(N + 1);
        chk("disabled_no_valid", 64'(valid_seen), 64'(0));
        chk("disabled_no_underflow", 64'(udf_seen), 64'(0));
        finish_interval();

        // Randomized intervals.
        for (int f = 0; f < 6; f++) begin
            en_r = N'($urandom);
            do begin
                if ($urandom_range(0, 2) == 0)
                    step(1'b1, $urandom_range(0, N - 1), int'($urandom), int'($urandom));
                else
                    step(1'b0, 0, 0, 0);
            end while ((cyc % FI) != 0);
        end

        // Reset in the middle of a frame.
        en_r = 16'hFFFF;
        for (int k = 0; k < 8; k++) step(1'b1, $urandom_range(0, N - 1), int'($urandom), int'($urandom));
        finish_interval();
        while (cyc - f_base < 5) idle(1);
        rst_step();
        for (int k = 0; k < N; k++) step(1'b1, k, int'($urandom), int'($urandom));
        idle(FI + N - N);
        idle(N);
        chk("post_reset_first_frame", 64'(first_valid), 64'(FI));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
